// File: rtl/Mem.sv
// Shared memory-side types for the instruction cache: line addresses, words,
// lines, and the beat helper used to assemble refills.
package Mem;

    localparam int unsigned LINE_ADDR_W = 28;
    localparam int unsigned WORD_W      = 32;
    localparam int unsigned BEATS       = 4;
    localparam int unsigned LINE_W      = WORD_W * BEATS;

    typedef logic [LINE_ADDR_W-1:0] lineaddr_t;
    typedef logic [WORD_W-1:0]      word_t;
    typedef logic [LINE_W-1:0]      line_t;
    typedef logic [1:0]             beat_t;

    // Return line with word slot 'beat' replaced; beat k lands at bits 32k+31:32k.
    function automatic line_t put_word(input line_t line, input beat_t beat, input word_t word);
        line_t res;
        res = line;
        case (beat)
            2'd0:    res[31:0]   = word;
            2'd1:    res[63:32]  = word;
            2'd2:    res[95:64]  = word;
            default: res[127:96] = word;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/l1icache_core_if.sv
// Core-side fetch port of the L1 instruction cache.
interface l1icache_core_if;

    logic           req_valid;
    Mem::lineaddr_t req_addr;
    logic           req_ready;
    logic           resp_valid;
    Mem::line_t     resp_data;
    logic           flush;

    modport server (
        input  req_valid, req_addr, flush,
        output req_ready, resp_valid, resp_data
    );

    modport client (
        output req_valid, req_addr, flush,
        input  req_ready, resp_valid, resp_data
    );

endinterface

// File: rtl/l1_icache_array.sv
// Direct-mapped tag/valid/data storage: registered read port, one write port,
// and a single-set invalidate port used while flushing.
module l1_icache_array
    import Mem::*;
#(
    parameter int unsigned NUM_SETS = 64,
    localparam int unsigned IDX_W = $clog2(NUM_SETS),
    localparam int unsigned TAG_W = LINE_ADDR_W - IDX_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rd_en,
    input  logic [IDX_W-1:0] rd_idx,
    output logic             rd_valid,
    output logic [TAG_W-1:0] rd_tag,
    output line_t            rd_data,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [TAG_W-1:0] wr_tag,
    input  line_t            wr_data,
    input  logic             clr_en,
    input  logic [IDX_W-1:0] clr_idx
);

    logic [NUM_SETS-1:0] valid_q, valid_d;
    logic                rd_valid_q, rd_valid_d;
    logic [TAG_W-1:0]    rd_tag_q;
    line_t               rd_data_q;
    logic [TAG_W-1:0]    tag_mem_q  [NUM_SETS];
    line_t               data_mem_q [NUM_SETS];

    // Valid bits: cleared together on reset, set by a fill, cleared by a flush step.
    always_comb begin
        valid_d    = valid_q;
        rd_valid_d = rd_valid_q;
        if (rst) begin
            valid_d    = '0;
            rd_valid_d = 1'b0;
        end else begin
            if (wr_en) begin
                valid_d[wr_idx] = 1'b1;
            end else begin
                valid_d = valid_d;
            end
            if (clr_en) begin
                valid_d[clr_idx] = 1'b0;
            end else begin
                valid_d = valid_d;
            end
            if (rd_en) begin
                rd_valid_d = valid_q[rd_idx];
            end else begin
                rd_valid_d = rd_valid_q;
            end
        end
    end

    // Storage and read registers; tag/data carry no reset since valid gates them.
    always_ff @(posedge clk) begin
        valid_q    <= valid_d;
        rd_valid_q <= rd_valid_d;
        if (rd_en) begin
            rd_tag_q  <= tag_mem_q[rd_idx];
            rd_data_q <= data_mem_q[rd_idx];
        end
        if (wr_en && !rst) begin
            tag_mem_q[wr_idx]  <= wr_tag;
            data_mem_q[wr_idx] <= wr_data;
        end
    end

    assign rd_valid = rd_valid_q;
    assign rd_tag   = rd_tag_q;
    assign rd_data  = rd_data_q;

endmodule

// File: rtl/l1_icache.sv
// Direct-mapped L1 instruction cache: one-cycle hit lookup, 4-beat line refill,
// and a set-by-set flush sequence.
module l1_icache
    import Mem::*;
#(
    parameter int unsigned NUM_SETS = 64
) (
    input  logic            clk,
    input  logic            rst,
    l1icache_core_if.server core,
    output logic            mem_req_valid,
    input  logic            mem_req_ready,
    output lineaddr_t       mem_req_addr,
    input  logic            mem_resp_valid,
    input  word_t           mem_resp_data
);

    localparam int unsigned      IDX_W    = $clog2(NUM_SETS);
    localparam int unsigned      TAG_W    = LINE_ADDR_W - IDX_W;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SETS - 1);

    typedef enum logic [1:0] {IDLE, MISS_REQ, MISS_FILL, FLUSH} state_e;

    state_e           state_q, state_d;
    logic             lookup_pend_q, lookup_pend_d;
    lineaddr_t        lookup_addr_q, lookup_addr_d;
    logic             mem_req_valid_q, mem_req_valid_d;
    lineaddr_t        mem_req_addr_q, mem_req_addr_d;
    beat_t            beat_q, beat_d;
    line_t            fill_line_q, fill_line_d;
    logic             fill_resp_q, fill_resp_d;
    line_t            resp_data_q, resp_data_d;
    logic             pend_flush_q, pend_flush_d;
    logic [IDX_W-1:0] flush_idx_q, flush_idx_d;

    logic             rd_valid_s;
    logic [TAG_W-1:0] rd_tag_s;
    line_t            rd_data_s;
    logic             tag_match_s, hit_s, miss_s, req_ready_s, accept_s, last_beat_s;
    line_t            fill_line_s;

    // A flush in the lookup cycle discards the lookup outright, hit or miss.
    assign tag_match_s = rd_valid_s && (rd_tag_s == lookup_addr_q[LINE_ADDR_W-1:IDX_W]);
    assign hit_s       = lookup_pend_q && !core.flush && tag_match_s;
    assign miss_s      = lookup_pend_q && !core.flush && !tag_match_s;
    assign req_ready_s = (state_q == IDLE) && !core.flush && !miss_s;
    assign accept_s    = core.req_valid && req_ready_s;
    assign last_beat_s = (state_q == MISS_FILL) && mem_resp_valid && (beat_q == 2'd3);
    assign fill_line_s = put_word(fill_line_q, beat_q, mem_resp_data);

    l1_icache_array #(.NUM_SETS(NUM_SETS)) u_array (
        .clk      (clk),
        .rst      (rst),
        .rd_en    (accept_s),
        .rd_idx   (core.req_addr[IDX_W-1:0]),
        .rd_valid (rd_valid_s),
        .rd_tag   (rd_tag_s),
        .rd_data  (rd_data_s),
        .wr_en    (last_beat_s && !rst),
        .wr_idx   (mem_req_addr_q[IDX_W-1:0]),
        .wr_tag   (mem_req_addr_q[LINE_ADDR_W-1:IDX_W]),
        .wr_data  (fill_line_s),
        .clr_en   ((state_q == FLUSH) && !rst),
        .clr_idx  (flush_idx_q)
    );

    // Next-state and next-output computation for the controller.
    always_comb begin
        state_d         = state_q;
        lookup_pend_d   = accept_s;
        lookup_addr_d   = accept_s ? core.req_addr : lookup_addr_q;
        mem_req_valid_d = mem_req_valid_q;
        mem_req_addr_d  = mem_req_addr_q;
        beat_d          = beat_q;
        fill_line_d     = fill_line_q;
        fill_resp_d     = 1'b0;
        resp_data_d     = hit_s ? rd_data_s : resp_data_q;
        pend_flush_d    = pend_flush_q;
        flush_idx_d     = flush_idx_q;
        case (state_q)
            IDLE: begin
                if (core.flush) begin
                    state_d     = FLUSH;
                    flush_idx_d = '0;
                end else if (miss_s) begin
                    state_d         = MISS_REQ;
                    mem_req_valid_d = 1'b1;
                    mem_req_addr_d  = lookup_addr_q;
                end else begin
                    state_d = IDLE;
                end
            end
            MISS_REQ: begin
                pend_flush_d = pend_flush_q | core.flush;
                if (mem_req_ready) begin
                    state_d         = MISS_FILL;
                    mem_req_valid_d = 1'b0;
                    beat_d          = 2'd0;
                end else begin
                    state_d = MISS_REQ;
                end
            end
            MISS_FILL: begin
                pend_flush_d = pend_flush_q | core.flush;
                if (mem_resp_valid) begin
                    fill_line_d = fill_line_s;
                    beat_d      = beat_q + 2'd1;
                    if (last_beat_s) begin
                        // A flush seen during the refill runs once the line is delivered.
                        fill_resp_d  = 1'b1;
                        resp_data_d  = fill_line_s;
                        pend_flush_d = 1'b0;
                        flush_idx_d  = '0;
                        state_d      = (pend_flush_q || core.flush) ? FLUSH : IDLE;
                    end else begin
                        state_d = MISS_FILL;
                    end
                end else begin
                    state_d = MISS_FILL;
                end
            end
            FLUSH: begin
                if (core.flush) begin
                    flush_idx_d = '0;
                end else if (flush_idx_q == LAST_IDX) begin
                    state_d = IDLE;
                end else begin
                    flush_idx_d = flush_idx_q + IDX_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Controller registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            lookup_pend_q   <= 1'b0;
            lookup_addr_q   <= '0;
            mem_req_valid_q <= 1'b0;
            mem_req_addr_q  <= '0;
            beat_q          <= 2'd0;
            fill_line_q     <= '0;
            fill_resp_q     <= 1'b0;
            resp_data_q     <= '0;
            pend_flush_q    <= 1'b0;
            flush_idx_q     <= '0;
        end else begin
            state_q         <= state_d;
            lookup_pend_q   <= lookup_pend_d;
            lookup_addr_q   <= lookup_addr_d;
            mem_req_valid_q <= mem_req_valid_d;
            mem_req_addr_q  <= mem_req_addr_d;
            beat_q          <= beat_d;
            fill_line_q     <= fill_line_d;
            fill_resp_q     <= fill_resp_d;
            resp_data_q     <= resp_data_d;
            pend_flush_q    <= pend_flush_d;
            flush_idx_q     <= flush_idx_d;
        end
    end

    assign core.req_ready  = req_ready_s;
    assign core.resp_valid = hit_s || fill_resp_q;
    assign core.resp_data  = hit_s ? rd_data_s : resp_data_q;
    assign mem_req_valid   = mem_req_valid_q;
    assign mem_req_addr    = mem_req_addr_q;

endmodule

// File: tb/tb_l1_icache.sv
// Directed bench for l1_icache: cold miss, hit streaming, conflicts, flushes,
// refill stall and reset in the middle of a refill.
module tb_l1_icache;
    import Mem::*;

    logic      clk = 1'b0;
    logic      rst;
    logic      mem_req_valid;
    logic      mem_req_ready;
    lineaddr_t mem_req_addr;
    logic      mem_resp_valid;
    word_t     mem_resp_data;
    int        vec_cnt  = 0;
    int        miss_cnt = 0;

    localparam line_t L1 = 128'h00000044_00000033_00000022_00000011;
    localparam line_t L2 = 128'h000000A4_000000A3_000000A2_000000A1;
    localparam line_t L4 = 128'h000000B4_000000B3_000000B2_000000B1;
    localparam line_t L5 = 128'h000000D4_000000D3_000000D2_000000D1;
    localparam line_t L6 = 128'h000000E4_000000E3_000000E2_000000E1;

    l1icache_core_if core_if ();

    l1_icache #(.NUM_SETS(64)) dut (
        .clk            (clk),
        .rst            (rst),
        .core           (core_if),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_addr   (mem_req_addr),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_data  (mem_resp_data)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one request for a cycle; report ready then and resp_valid a cycle later.
    task automatic lookup(input lineaddr_t a, output logic rdy, output logic rv);
        core_if.req_valid = 1'b1;
        core_if.req_addr  = a;
        #1;
        rdy = core_if.req_ready;
        tick();
        core_if.req_valid = 1'b0;
        #1;
        rv = core_if.resp_valid;
    endtask

    // Wait (bounded) for a refill request, accept it, return 4 beats, sample the response cycle.
    task automatic refill(input word_t w0, input word_t w1, input word_t w2, input word_t w3,
                          output logic got, output lineaddr_t a, output logic rv, output line_t d);
        word_t w [4];
        w   = '{w0, w1, w2, w3};
        got = 1'b0;
        a   = '0;
        rv  = 1'b0;
        d   = '0;
        for (int i = 0; i < 20 && !got; i++) begin
            if (mem_req_valid === 1'b1) got = 1'b1;
            else begin
                tick();
                #1;
            end
        end
        if (got) begin
            a = mem_req_addr;
            mem_req_ready = 1'b1;
            tick();
            mem_req_ready = 1'b0;
            for (int k = 0; k < 4; k++) begin
                mem_resp_valid = 1'b1;
                mem_resp_data  = w[k];
                tick();
            end
            mem_resp_valid = 1'b0;
            #1;
            rv = core_if.resp_valid;
            d  = core_if.resp_data;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
        vec_cnt++;
        if (core_if.req_ready !== 1'b1) begin
            miss_cnt++; $display("FAIL reset_req_ready: got %b want 1", core_if.req_ready);
        end
        vec_cnt++;
        if (core_if.resp_valid !== 1'b0) begin
            miss_cnt++; $display("FAIL reset_resp_valid: got %b want 0", core_if.resp_valid);
        end
        vec_cnt++;
        if (core_if.resp_data !== 128'h0) begin
            miss_cnt++; $display("FAIL reset_resp_data: got %h want 0", core_if.resp_data);
        end
        vec_cnt++;
        if ({mem_req_valid, mem_req_addr} !== {1'b0, 28'h0}) begin
            miss_cnt++; $display("FAIL reset_mem_req: got %b/%h want 0/0", mem_req_valid, mem_req_addr);
        end
    endtask

    task automatic test_cold_miss();
        logic got, rv;
        lineaddr_t a;
        line_t d;
        core_if.req_valid = 1'b1;
        core_if.req_addr  = 28'h0000010;
        #1;
        vec_cnt++;
        if (core_if.req_ready !== 1'b1) begin
            miss_cnt++; $display("FAIL cold_accept: got %b want 1", core_if.req_ready);
        end
        tick();
        core_if.req_valid = 1'b0;
        #1;
        vec_cnt++;
        if ({core_if.resp_valid, core_if.req_ready} !== 2'b00) begin
            miss_cnt++; $display("FAIL cold_miss_cycle: got rv/rdy %b%b want 00", core_if.resp_valid, core_if.req_ready);
        end
        tick();
        #1;
        vec_cnt++;
        if ({mem_req_valid, mem_req_addr} !== {1'b1, 28'h0000010}) begin
            miss_cnt++; $display("FAIL cold_mem_req: got %b/%h want 1/0000010", mem_req_valid, mem_req_addr);
        end
        refill(32'h11, 32'h22, 32'h33, 32'h44, got, a, rv, d);
        vec_cnt++;
        if ({got, rv} !== 2'b11) begin
            miss_cnt++; $display("FAIL cold_resp_valid: got req/rv %b%b want 11", got, rv);
        end
        vec_cnt++;
        if (d !== L1) begin
            miss_cnt++; $display("FAIL cold_resp_data: got %h want %h", d, L1);
        end
        tick();
        #1;
        vec_cnt++;
        if ({core_if.resp_valid, core_if.resp_data, core_if.req_ready} !== {1'b0, L1, 1'b1}) begin
            miss_cnt++; $display("FAIL cold_after_pulse: got rv %b data %h rdy %b want 0 %h 1",
                                 core_if.resp_valid, core_if.resp_data, core_if.req_ready, L1);
        end
    endtask

    task automatic test_back_to_back();
        core_if.req_valid = 1'b1;
        core_if.req_addr  = 28'h0000010;
        #1;
        vec_cnt++;
        if (core_if.req_ready !== 1'b1) begin
            miss_cnt++; $display("FAIL b2b_accept: got %b want 1", core_if.req_ready);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            if (i == 2) core_if.req_valid = 1'b0;
            #1;
            vec_cnt++;
            if ({core_if.resp_valid, core_if.resp_data, mem_req_valid} !== {1'b1, L1, 1'b0}) begin
                miss_cnt++; $display("FAIL b2b_hit%0d: got rv %b data %h mreq %b want 1 %h 0",
                                     i, core_if.resp_valid, core_if.resp_data, mem_req_valid, L1);
            end
            if (i < 2) begin
                vec_cnt++;
                if (core_if.req_ready !== 1'b1) begin
                    miss_cnt++; $display("FAIL b2b_ready%0d: got %b want 1", i, core_if.req_ready);
                end
            end
        end
        tick();
        #1;
        vec_cnt++;
        if ({core_if.resp_valid, mem_req_valid} !== 2'b00) begin
            miss_cnt++; $display("FAIL b2b_end: got rv/mreq %b%b want 00", core_if.resp_valid, mem_req_valid);
        end
    endtask

    task automatic test_conflict();
        logic rdy, rv, got;
        lineaddr_t a;
        line_t d;
        lookup(28'h0000050, rdy, rv);
        vec_cnt++;
        if ({rdy, rv} !== 2'b10) begin
            miss_cnt++; $display("FAIL conflict_miss: got rdy/rv %b%b want 10", rdy, rv);
        end
        refill(32'hA1, 32'hA2, 32'hA3, 32'hA4, got, a, rv, d);
        vec_cnt++;
        if ({got, a, rv, d} !== {1'b1, 28'h0000050, 1'b1, L2}) begin
            miss_cnt++; $display("FAIL conflict_fill: got req %b addr %h rv %b data %h want 1 0000050 1 %h", got, a, rv, d, L2);
        end
        lookup(28'h0000010, rdy, rv);
        vec_cnt++;
        if ({rdy, rv} !== 2'b10) begin
            miss_cnt++; $display("FAIL conflict_remiss: got rdy/rv %b%b want 10", rdy, rv);
        end
        refill(32'h11, 32'h22, 32'h33, 32'h44, got, a, rv, d);
        vec_cnt++;
        if ({got, a, rv, d} !== {1'b1, 28'h0000010, 1'b1, L1}) begin
            miss_cnt++; $display("FAIL conflict_refill: got req %b addr %h rv %b data %h want 1 0000010 1 %h", got, a, rv, d, L1);
        end
    endtask

    task automatic test_flush_idle();
        logic rdy, rv, got, done;
        lineaddr_t a;
        line_t d;
        int n;
        core_if.req_valid = 1'b1;
        core_if.req_addr  = 28'h0000010;
        tick();
        core_if.req_valid = 1'b0;
        core_if.flush     = 1'b1;
        #1;
        vec_cnt++;
        if (core_if.resp_valid !== 1'b0) begin
            miss_cnt++; $display("FAIL flush_drop_resp: got %b want 0", core_if.resp_valid);
        end
        n    = 0;
        done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            if (i > 0) begin
                tick();
                core_if.flush = (i == 11);
                #1;
            end
            if (core_if.req_ready === 1'b0) n++;
            else done = 1'b1;
        end
        core_if.flush = 1'b0;
        vec_cnt++;
        if (!done || n != 76) begin
            miss_cnt++; $display("FAIL flush_restart_len: got %0d busy cycles (done %b) want 76", n, done);
        end
        lookup(28'h0000010, rdy, rv);
        vec_cnt++;
        if ({rdy, rv} !== 2'b10) begin
            miss_cnt++; $display("FAIL flush_idle_miss: got rdy/rv %b%b want 10", rdy, rv);
        end
        refill(32'h11, 32'h22, 32'h33, 32'h44, got, a, rv, d);
        vec_cnt++;
        if ({got, a, rv, d} !== {1'b1, 28'h0000010, 1'b1, L1}) begin
            miss_cnt++; $display("FAIL flush_idle_refill: got req %b addr %h rv %b data %h want 1 0000010 1 %h", got, a, rv, d, L1);
        end
    endtask

    task automatic test_flush_in_fill();
        logic rdy, rv, got, done;
        lineaddr_t a;
        line_t d;
        int n;
        lookup(28'h0000090, rdy, rv);
        vec_cnt++;
        if ({rdy, rv} !== 2'b10) begin
            miss_cnt++; $display("FAIL ffill_miss: got rdy/rv %b%b want 10", rdy, rv);
        end
        tick();
        #1;
        vec_cnt++;
        if ({mem_req_valid, mem_req_addr} !== {1'b1, 28'h0000090}) begin
            miss_cnt++; $display("FAIL ffill_mem_req: got %b/%h want 1/0000090", mem_req_valid, mem_req_addr);
        end
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b1;
        mem_resp_data  = 32'hB1;
        tick();
        mem_resp_data  = 32'hB2;
        tick();
        mem_resp_valid = 1'b0;
        core_if.flush  = 1'b1;
        #1;
        vec_cnt++;
        if (core_if.req_ready !== 1'b0) begin
            miss_cnt++; $display("FAIL ffill_ready: got %b want 0", core_if.req_ready);
        end
        tick();
        core_if.flush  = 1'b0;
        mem_resp_valid = 1'b1;
        mem_resp_data  = 32'hB3;
        tick();
        mem_resp_data  = 32'hB4;
        tick();
        mem_resp_valid = 1'b0;
        #1;
        vec_cnt++;
        if ({core_if.resp_valid, core_if.resp_data} !== {1'b1, L4}) begin
            miss_cnt++; $display("FAIL ffill_resp: got rv %b data %h want 1 %h", core_if.resp_valid, core_if.resp_data, L4);
        end
        n    = 0;
        done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            if (i > 0) tick();
            #1;
            if (core_if.req_ready === 1'b0) n++;
            else done = 1'b1;
        end
        vec_cnt++;
        if (!done || n != 64) begin
            miss_cnt++; $display("FAIL ffill_flush_len: got %0d busy cycles (done %b) want 64", n, done);
        end
        lookup(28'h0000010, rdy, rv);
        vec_cnt++;
        if ({rdy, rv} !== 2'b10) begin
            miss_cnt++; $display("FAIL ffill_post_miss: got rdy/rv %b%b want 10", rdy, rv);
        end
        refill(32'h11, 32'h22, 32'h33, 32'h44, got, a, rv, d);
        vec_cnt++;
        if ({got, a, rv, d} !== {1'b1, 28'h0000010, 1'b1, L1}) begin
            miss_cnt++; $display("FAIL ffill_post_refill: got req %b addr %h rv %b data %h want 1 0000010 1 %h", got, a, rv, d, L1);
        end
    endtask

    task automatic test_stall();
        logic rdy, rv, got;
        lineaddr_t a;
        line_t d;
        lookup(28'h0000123, rdy, rv);
        vec_cnt++;
        if ({rdy, rv} !== 2'b10) begin
            miss_cnt++; $display("FAIL stall_miss: got rdy/rv %b%b want 10", rdy, rv);
        end
        tick();
        core_if.req_valid = 1'b1;
        core_if.req_addr  = 28'h0000010;
        mem_req_ready     = 1'b0;
        for (int i = 0; i < 10; i++) begin
            #1;
            vec_cnt++;
            if ({mem_req_valid, mem_req_addr, core_if.req_ready, core_if.resp_valid, core_if.resp_data}
                    !== {1'b1, 28'h0000123, 1'b0, 1'b0, L1}) begin
                miss_cnt++; $display("FAIL stall_cycle%0d: got mreq %b addr %h rdy %b rv %b data %h",
                                     i, mem_req_valid, mem_req_addr, core_if.req_ready, core_if.resp_valid, core_if.resp_data);
            end
            tick();
        end
        core_if.req_valid = 1'b0;
        refill(32'hD1, 32'hD2, 32'hD3, 32'hD4, got, a, rv, d);
        vec_cnt++;
        if ({got, a, rv, d} !== {1'b1, 28'h0000123, 1'b1, L5}) begin
            miss_cnt++; $display("FAIL stall_refill: got req %b addr %h rv %b data %h want 1 0000123 1 %h", got, a, rv, d, L5);
        end
    endtask

    task automatic test_reset_mid_refill();
        logic rdy, rv, got;
        lineaddr_t a;
        line_t d;
        word_t late [4];
        late = '{32'h77, 32'h88, 32'h99, 32'h0};
        lookup(28'h0000200, rdy, rv);
        vec_cnt++;
        if ({rdy, rv} !== 2'b10) begin
            miss_cnt++; $display("FAIL rstfill_miss: got rdy/rv %b%b want 10", rdy, rv);
        end
        tick();
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b1;
        mem_resp_data  = 32'h55;
        tick();
        rst           = 1'b1;
        mem_resp_data = 32'h66;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            mem_resp_valid = (i < 3);
            mem_resp_data  = late[i];
            #1;
            vec_cnt++;
            if ({core_if.resp_valid, core_if.resp_data, mem_req_valid} !== {1'b0, 128'h0, 1'b0}) begin
                miss_cnt++; $display("FAIL rstfill_ignore%0d: got rv %b data %h mreq %b want 0 0 0",
                                     i, core_if.resp_valid, core_if.resp_data, mem_req_valid);
            end
            tick();
        end
        mem_resp_valid = 1'b0;
        lookup(28'h0000200, rdy, rv);
        vec_cnt++;
        if ({rdy, rv} !== 2'b10) begin
            miss_cnt++; $display("FAIL rstfill_remiss: got rdy/rv %b%b want 10", rdy, rv);
        end
        refill(32'hE1, 32'hE2, 32'hE3, 32'hE4, got, a, rv, d);
        vec_cnt++;
        if ({got, a, rv, d} !== {1'b1, 28'h0000200, 1'b1, L6}) begin
            miss_cnt++; $display("FAIL rstfill_refill: got req %b addr %h rv %b data %h want 1 0000200 1 %h", got, a, rv, d, L6);
        end
    endtask

    initial begin
        rst               = 1'b1;
        core_if.req_valid = 1'b0;
        core_if.req_addr  = '0;
        core_if.flush     = 1'b0;
        mem_req_ready     = 1'b0;
        mem_resp_valid    = 1'b0;
        mem_resp_data     = '0;
        test_reset();
        test_cold_miss();
        test_back_to_back();
        test_conflict();
        test_flush_idle();
        test_flush_in_fill();
        test_stall();
        test_reset_mid_refill();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
